truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture engine: the "reader" side of a 4-input Cello logic design.
- Drives all 16 input combinations into a combinational gate netlist (in1..in4 -> out). Samples the response and reconstructs the 16-bit Cello truth-table hex code.
- Compares the captured code against an expected code.
- Sits in the verification/characterisation harness next to each generated design module.

Parameters:
- SETTLE_CYCLES, 8, cycles held per row before sampling; legal range 2..255, and must cover the 2-flop response synchroniser.
- SAMPLES, 3, consecutive samples per row; odd, legal range 1..15.
- EXPECTED, 16'h1714, truth-table code the captured result is compared against.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
- in1  out  1  stimulus to the design under test, row bit 3 (MSB)
- in2  out  1  stimulus, row bit 2
- in3  out  1  stimulus, row bit 1
- in4  out  1  stimulus, row bit 0 (LSB)
- resp  in  1  design output; asynchronous to clk
- busy  out  1  high from start acceptance through DONE
- row  out  4  row currently driven
- done  out  1  one-cycle pulse when the sweep completes
- tt  out  16  captured truth table
- match  out  1  tt == EXPECTED; valid when done is pulsed, then held
- unstable  out  1  at least one row saw disagreeing samples

Behaviour:
- Reset values: in1..in4=0, row=0, busy=0, done=0, tt=0, match=0, unstable=0, state=IDLE, both synchroniser flops=0.
- Reset asserted mid-sweep aborts the sweep in the next cycle and applies all reset values. No done pulse is produced.
- resp passes through a 2-flop synchroniser. Only the synchronised value is sampled.
- Row mapping: in1=row[3], in2=row[2], in3=row[1], in4=row[0]. The row result is written to tt[15-row], so row 0 (all inputs 0) lands in the MSB.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE. On the same edge: row=0, tt=0, unstable=0, match=0, busy=1, settle counter cleared.
  - start=0 -> stay in IDLE; outputs hold their last values.
- SETTLE: inputs held at row. After SETTLE_CYCLES cycles -> SAMPLE, with the ones-counter and sample counter cleared.
- SAMPLE:
  - Each cycle, add the synchronised resp to the ones-counter.
  - After SAMPLES cycles, write tt[15-row] = (ones > SAMPLES/2).
  - If 0 < ones < SAMPLES, set unstable (sticky for the rest of the sweep).
  - If row==15 -> DONE; otherwise increment row and go to SETTLE. The new row is driven on that same edge.
- DONE: lasts one cycle; done=1, match=(tt==EXPECTED); then IDLE with busy=0. Captured tt and match hold until the next accepted start.
- Latency: done is high exactly 16*(SETTLE_CYCLES+SAMPLES)+1 cycles after the start-accept edge. With defaults this is 177.
- start asserted while busy is ignored, with no effect on state or counters.
- start and rst asserted together: rst wins.
- row is a 4-bit counter with no wrap inside a sweep. 15 is terminal.
- Counter widths: settle counter 8 bits; sample and ones counters 4 bits each.
- Out-of-range SETTLE_CYCLES or SAMPLES, or an even SAMPLES, is a parameter error: elaboration-time $error.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - localparam N_ROWS=16 and localparam TT_W=16;
  - function tt_index(row) = 15-row.
- One natural sub-module: resp_voter. It contains the 2-flop synchroniser and the ones-counter, with inputs clear and enable. Outputs: maj and disagree.

Test Plan:
- DUT = gate-level model of function out = (~in1&in2&in3) | (in4&(in2^in3)); pulse start -> after 177 cycles, done=1, tt=16'h1714, match=1, unstable=0.
- DUT tied resp=0 -> tt=16'h0000, match=0. DUT tied resp=1 -> tt=16'hFFFF, match=0. busy low in the cycle after done in both cases.
- resp toggles every cycle while row==5 (other rows per the 0x1714 model) -> unstable=1, and tt bit 10 equals the majority of the 3 samples.
- Pulse start again at cycle 40 of a sweep -> no restart; done still at cycle 177 and row sequence 0..15 uninterrupted.
- Assert rst at row 7 -> next cycle all outputs are at reset values and there is no done pulse. A fresh start then completes normally with tt=16'h1714.
- Check stimulus ordering: record in1..in4 at each SETTLE entry -> values 0000,0001,...,1111 in order, each held for exactly 11 cycles with defaults.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding, sizes and row-to-bit mapping for the truth-table sweeper
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
    localparam int N_ROWS = 16;
    localparam int TT_W = 16;
    // row 0 (all inputs low) lands in the MSB of the Cello code
    function automatic logic [3:0] tt_index(input logic [3:0] row);
        return 4'(TT_W - 1) - row;
    endfunction
endpackage

// File: rtl/resp_voter.sv
// resp_voter: 2-flop synchroniser for the async response plus a ones-counter majority voter
module resp_voter #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic resp_i,
    input  logic clear_i,
    input  logic en_i,
    output logic maj_o,
    output logic disagree_o
);
    logic       s1_q, s2_q;
    logic [3:0] ones_q, ones_d;
    // maj/disagree include the sample taken this cycle, so they are final on the last sample
    assign ones_d = ones_q + {3'b000, s2_q};
    assign maj_o = ones_d > 4'(SAMPLES / 2);
    assign disagree_o = (ones_d != 4'd0) && (ones_d != 4'(SAMPLES));
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            ones_q <= '0;
        end else begin
            s1_q <= resp_i;
            s2_q <= s1_q;
            if (clear_i)
                ones_q <= '0;
            else if (en_i)
                ones_q <= ones_d;
        end
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 input rows into a 4-input design and captures its truth table
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 8,
    parameter int          SAMPLES       = 3,
    parameter logic [15:0] EXPECTED      = 16'h1714
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    input  logic        resp,
    output logic        busy,
    output logic [3:0]  row,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic        unstable
);
    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 2..255");
    end
    if (SAMPLES < 1 || SAMPLES > 15 || (SAMPLES % 2) == 0) begin : g_bad_samples
        $error("SAMPLES must be odd and in 1..15");
    end

    state_e      state_q;
    logic [3:0]  row_q, samp_q;
    logic [7:0]  settle_q;
    logic [15:0] tt_q;
    logic        busy_q, done_q, match_q, unst_q;
    logic        settle_end, last_sample, maj, disagree;

    assign settle_end  = (state_q == SETTLE) && (settle_q == 8'(SETTLE_CYCLES - 1));
    assign last_sample = samp_q == 4'(SAMPLES - 1);

    resp_voter #(.SAMPLES(SAMPLES)) u_voter (
        .clk        (clk),
        .rst        (rst),
        .resp_i     (resp),
        .clear_i    (settle_end),
        .en_i       (state_q == SAMPLE),
        .maj_o      (maj),
        .disagree_o (disagree)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            samp_q   <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            unst_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= SETTLE;
                        row_q    <= '0;
                        tt_q     <= '0;
                        unst_q   <= 1'b0;
                        match_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        settle_q <= '0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_end) begin
                        state_q <= SAMPLE;
                        samp_q  <= '0;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (last_sample) begin
                        tt_q[tt_index(row_q)] <= maj;
                        if (disagree)
                            unst_q <= 1'b1;
                        if (row_q == 4'(N_ROWS - 1)) begin
                            state_q <= DONE;
                        end else begin
                            row_q    <= row_q + 4'd1;
                            settle_q <= '0;
                            state_q  <= SETTLE;
                        end
                    end else begin
                        samp_q <= samp_q + 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    match_q <= tt_q == EXPECTED;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {in1, in2, in3, in4} = row_q;
    assign row      = row_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign match    = match_q;
    assign unstable = unst_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench sweeping a gate model of the 0x1714 function and fixed responses
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        resp, f, tog = 1'b0;
    logic        in1, in2, in3, in4, busy, done, match, unstable;
    logic [3:0]  row;
    logic [15:0] tt;
    int          mode = 0;
    int          cyc_g = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic        unst;
        int          t_acc;
    } exp_t;
    exp_t q[$];
    exp_t e_m;

    truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .resp(resp), .busy(busy), .row(row), .done(done),
        .tt(tt), .match(match), .unstable(unstable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    assign f = (~in1 & in2 & in3) | (in4 & (in2 ^ in3));
    assign resp = (mode == 1) ? 1'b0 :
                  (mode == 2) ? 1'b1 :
                  (mode == 3 && row == 4'd5) ? tog : f;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // monitor: pops an expectation whenever the DUT pulses done
    initial forever begin
        @(posedge clk);
        #1;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_m = q.pop_front();
                chk("latency", 32'(cyc_g - e_m.t_acc), 32'd177);
                chk("tt", 32'(tt), 32'(e_m.tt));
                chk("match", 32'(match), 32'(e_m.match));
                chk("unstable", 32'(unstable), 32'(e_m.unst));
                chk("busy_at_done", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_one_cycle", 32'(done), 32'd0);
            end
        end
    end

    task automatic sweep(input int m, input logic [15:0] ett, input logic em, input logic eu,
                         input int restart_at, input int abort_row);
        int t, w;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tog = 1'b1;
        t = cyc_g;
        if (abort_row < 0)
            q.push_back(exp_t'{ett, em, eu, t});
        chk("busy_on_accept", 32'(busy), 32'd1);
        for (int c = 1; c <= 176; c++) begin
            @(posedge clk);
            #1;
            tog = ~c[0];
            start = (c == restart_at);
            w = (c / 11 > 15) ? 15 : c / 11;
            if (c % 11 == 0 || c % 11 == 10) begin
                chk("row", 32'(row), 32'(w));
                chk("stim", 32'({in1, in2, in3, in4}), 32'(w));
            end
            if (abort_row >= 0 && c == 11 * abort_row) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_row", 32'(row), 32'd0);
                chk("rst_stim", 32'({in1, in2, in3, in4}), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_tt", 32'(tt), 32'd0);
                chk("rst_match", 32'(match), 32'd0);
                chk("rst_unstable", 32'(unstable), 32'd0);
                repeat (200) @(posedge clk);
                return;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tt", 32'(tt), 32'd0);
        chk("reset_row", 32'(row), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_unstable", 32'(unstable), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        sweep(0, 16'h1714, 1'b1, 1'b0, -1, -1);
        sweep(1, 16'h0000, 1'b0, 1'b0, -1, -1);
        sweep(2, 16'hFFFF, 1'b0, 1'b0, -1, -1);
        // row 5 toggles: its synchronised samples read 0,1,0 so bit 10 votes 0
        sweep(3, 16'h1314, 1'b0, 1'b1, -1, -1);
        sweep(0, 16'h1714, 1'b1, 1'b0, 40, -1);
        sweep(0, 16'h0000, 1'b0, 1'b0, -1, 7);
        sweep(0, 16'h1714, 1'b1, 1'b0, -1, -1);
        repeat (5) @(posedge clk);
        chk("all_done_seen", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
